// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the load/store bus controller: access widths,
// exception codes, FSM states and the load-data extension helper.
package lsu_bus_ctrl_pkg;

   localparam logic [1:0] LS_W = 2'b00;
   localparam logic [1:0] LS_H = 2'b01;
   localparam logic [1:0] LS_B = 2'b10;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   localparam logic [31:0] DEV_WIN_BYTES = 32'd12;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CHECK = 2'b01,
      S_BUS   = 2'b10,
      S_RESP  = 2'b11
   } state_e;

   // Picks the addressed lane out of the raw bus word and sign/zero-extends it.
   function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                               input logic [1:0]  op,
                                               input logic        sgn,
                                               input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      b = raw[{off, 3'b000} +: 8];
      h = off[1] ? raw[31:16] : raw[15:0];
      case (op)
         LS_B:    return {{24{sgn & b[7]}}, b};
         LS_H:    return {{16{sgn & h[15]}}, h};
         default: return raw;
      endcase
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Shared data-bus signals between the LSU (master) and the DM/timer fabric (slave).
interface lsu_bus_ctrl_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );

endinterface

// File: rtl/lsu_bus_ctrl_lane_gen.sv
// Combinational lane decode: byte enables, lane-replicated store data and
// alignment / address-map legality for one latched access.
module lsu_lane_gen
   import lsu_bus_ctrl_pkg::*;
#(
   parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
   parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
   parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
   input  logic [1:0]  ls_op,
   input  logic        req_we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic        fault,
   output logic [4:0]  fault_code
);

   logic misalign;
   logic in_dm;
   logic in_dev;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
      be         = 4'b0000;
      lane_wdata = wdata;
      misalign   = 1'b1;
      case (ls_op)
         LS_W: begin
            be       = 4'b1111;
            misalign = |addr[1:0];
         end
         LS_H: begin
            be         = 4'b0011 << {addr[1], 1'b0};
            lane_wdata = {2{wdata[15:0]}};
            misalign   = addr[0];
         end
         LS_B: begin
            be         = 4'b0001 << addr[1:0];
            lane_wdata = {4{wdata[7:0]}};
            misalign   = 1'b0;
         end
         default: ;
      endcase
   end

   assign in_dm  = (addr <= DM_TOP);
   assign in_dev = ((addr >= DEV0_BASE) && (addr < DEV0_BASE + DEV_WIN_BYTES)) ||
                   ((addr >= DEV1_BASE) && (addr < DEV1_BASE + DEV_WIN_BYTES));

   // Timer registers are word-only.
   assign fault      = misalign || (!in_dm && !in_dev) || (in_dev && (ls_op != LS_W));
   assign fault_code = req_we ? EXC_ADES : EXC_ADEL;

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store controller: IDLE -> CHECK -> BUS -> RESP, with bus
// timeout, exception reporting and load-data extension.
module lsu_bus_ctrl
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
   parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
   parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   input  logic                 req_we,
   input  logic [1:0]           ls_op,
   input  logic                 ls_sign,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   output logic                 stall,
   output logic                 done,
   output logic [31:0]          rdata,
   output logic                 exc_valid,
   output logic [4:0]           exc_code,
   lsu_bus_ctrl_if.master       bus
);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [1:0]  op_q, op_d;
   logic        sign_q, sign_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        exc_q, exc_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:0] rdata_q, rdata_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;

   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic        fault;
   logic [4:0]  fault_code;

   lsu_lane_gen #(
      .DM_TOP    (DM_TOP),
      .DEV0_BASE (DEV0_BASE),
      .DEV1_BASE (DEV1_BASE)
   ) u_lane_gen (
      .ls_op      (op_q),
      .req_we     (we_q),
      .addr       (addr_q),
      .wdata      (wdata_q),
      .be         (lane_be),
      .lane_wdata (lane_wdata),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      op_d        = op_q;
      sign_d      = sign_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      exc_d       = exc_q;
      exc_code_d  = exc_code_q;
      rdata_d     = rdata_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      stall       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               stall      = 1'b1;
               we_d       = req_we;
               op_d       = ls_op;
               sign_d     = ls_sign;
               addr_d     = addr;
               wdata_d    = wdata;
               exc_d      = 1'b0;
               exc_code_d = 5'd0;
               state_d    = S_CHECK;
            end
         end
         S_CHECK: begin
            stall = 1'b1;
            cnt_d = 8'd0;
            if (fault) begin
               exc_d      = 1'b1;
               exc_code_d = fault_code;
               state_d    = S_RESP;
            end else begin
               bus_req_d   = 1'b1;
               bus_we_d    = we_q;
               bus_addr_d  = {addr_q[31:2], 2'b00};
               bus_be_d    = lane_be;
               bus_wdata_d = lane_wdata;
               state_d     = S_BUS;
            end
         end
         S_BUS: begin
            stall = 1'b1;
            // An ack in the final timeout cycle still completes the access.
            if (bus.bus_ack) begin
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               cnt_d     = 8'd0;
               if (!we_q) rdata_d = load_extend(bus.bus_rdata, op_q, sign_q, addr_q[1:0]);
               state_d   = S_RESP;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               bus_req_d  = 1'b0;
               bus_we_d   = 1'b0;
               cnt_d      = 8'd0;
               exc_d      = 1'b1;
               exc_code_d = we_q ? EXC_ADES : EXC_ADEL;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         we_q        <= 1'b0;
         op_q        <= LS_W;
         sign_q      <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         exc_q       <= 1'b0;
         exc_code_q  <= 5'd0;
         rdata_q     <= 32'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         op_q        <= op_d;
         sign_q      <= sign_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         exc_q       <= exc_d;
         exc_code_q  <= exc_code_d;
         rdata_q     <= rdata_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   assign done          = (state_q == S_RESP);
   assign exc_valid     = done && exc_q;
   assign exc_code      = exc_code_q;
   assign rdata         = rdata_q;
   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_be    = bus_be_q;
   assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: expected responses are queued at request
// time and compared when done pulses.
module tb_lsu_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  ls_op;
   logic        ls_sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        exc_valid;
   logic [4:0]  exc_code;

   lsu_bus_ctrl_if bif();

   lsu_bus_ctrl #(
      .TIMEOUT   (16),
      .DM_TOP    (32'h0000_2FFF),
      .DEV0_BASE (32'h0000_7F00),
      .DEV1_BASE (32'h0000_7F10)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_we    (req_we),
      .ls_op     (ls_op),
      .ls_sign   (ls_sign),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .done      (done),
      .rdata     (rdata),
      .exc_valid (exc_valid),
      .exc_code  (exc_code),
      .bus       (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        exc;
      logic [4:0]  code;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_rd = 32'd0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ack_wait < 0 never acks; otherwise ack in BUS cycle ack_wait+1.
   task automatic run_access(input logic we, input logic [1:0] op, input logic sgn,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_wait, input logic [31:0] brd,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_rd, input logic exp_exc,
                             input logic [4:0] exp_code, input int exp_breq,
                             input int exp_cyc);
      exp_t e;
      int   breq;
      logic got;
      e.rdata = (we || exp_exc) ? last_rd : exp_rd;
      e.exc   = exp_exc;
      e.code  = exp_exc ? exp_code : 5'd0;
      e.cyc   = exp_cyc;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      ls_op     = op;
      ls_sign   = sgn;
      addr      = a;
      wdata     = wd;
      #1 check("stall_on_req", stall, 1);
      breq = 0;
      got  = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         req_valid   = 1'b0;
         bif.bus_ack = 1'b0;
         if (bif.bus_req) begin
            breq++;
            if (breq == 1) begin
               check("bus_be", bif.bus_be, exp_be);
               check("bus_addr", bif.bus_addr, {a[31:2], 2'b00});
               check("bus_we", bif.bus_we, we);
               if (we) check("bus_wdata", bif.bus_wdata, exp_wd);
            end
            if (ack_wait >= 0 && breq == ack_wait + 1) begin
               bif.bus_ack   = 1'b1;
               bif.bus_rdata = brd;
            end
         end
         if (done) begin
            got = 1'b1;
            e = sb.pop_front();
            check("done_cycle", c, e.cyc);
            check("rdata", rdata, e.rdata);
            check("exc_valid", exc_valid, e.exc);
            check("exc_code", exc_code, e.code);
            check("stall_resp", stall, 0);
            check("bus_req_resp", bif.bus_req, 0);
         end else begin
            check("stall_busy", stall, 1);
         end
      end
      if (!got) check("done_seen", 0, 1);
      check("bus_req_cycles", breq, exp_breq);
      if (!we && !exp_exc) last_rd = exp_rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n       = 1'b0;
      req_valid     = 1'b0;
      req_we        = 1'b0;
      ls_op         = 2'b00;
      ls_sign       = 1'b0;
      addr          = 32'd0;
      wdata         = 32'd0;
      bif.bus_ack   = 1'b0;
      bif.bus_rdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_exc_valid", exc_valid, 0);
      check("rst_exc_code", exc_code, 0);
      check("rst_rdata", rdata, 0);
      check("rst_bus_req", bif.bus_req, 0);
      check("rst_bus_we", bif.bus_we, 0);
      check("rst_bus_addr", bif.bus_addr, 0);
      check("rst_bus_be", bif.bus_be, 0);
      check("rst_bus_wdata", bif.bus_wdata, 0);
      reset_n = 1'b1;

      //         we  op     sg  addr          wdata         ackw brd           be       wd            rd            exc  code breq cyc
      run_access(0, 2'b00, 0, 32'h0000_0010, 32'h0,        0,  32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 5'd0, 1,  3);
      run_access(0, 2'b10, 1, 32'h0000_0013, 32'h0,        0,  32'h80FF_0102, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 5'd0, 1,  3);
      run_access(0, 2'b10, 0, 32'h0000_0013, 32'h0,        2,  32'h80FF_0102, 4'b1000, 32'h0,        32'h0000_0080, 0, 5'd0, 3,  5);
      run_access(1, 2'b01, 0, 32'h0000_0006, 32'hABCD_1234, 0, 32'h0,        4'b1100, 32'h1234_1234, 32'h0,        0, 5'd0, 1,  3);
      run_access(0, 2'b00, 0, 32'h0000_0002, 32'h0,        0,  32'h0,        4'b0000, 32'h0,        32'h0,        1, 5'd4, 0,  2);
      run_access(1, 2'b10, 0, 32'h0000_7F04, 32'h0000_0011, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 5'd5, 0,  2);
      run_access(0, 2'b00, 0, 32'h0000_0100, 32'h0,        -1, 32'h0,        4'b1111, 32'h0,        32'h0,        1, 5'd4, 16, 18);
      run_access(0, 2'b00, 0, 32'h0000_7F18, 32'h0,        1,  32'h1234_5678, 4'b1111, 32'h0,        32'h1234_5678, 0, 5'd0, 2,  4);
      run_access(0, 2'b01, 1, 32'h0000_2FFE, 32'h0,        0,  32'h8001_0000, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 5'd0, 1,  3);
      run_access(0, 2'b00, 0, 32'h0000_3000, 32'h0,        0,  32'h0,        4'b0000, 32'h0,        32'h0,        1, 5'd4, 0,  2);
      run_access(1, 2'b10, 0, 32'h0000_0002, 32'h0000_C35A, 0, 32'h0,       4'b0100, 32'h5A5A_5A5A, 32'h0,        0, 5'd0, 1,  3);
      run_access(0, 2'b00, 0, 32'h0000_0020, 32'h0,        15, 32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 5'd0, 16, 18);
      run_access(1, 2'b00, 0, 32'h0000_0104, 32'h1111_2222, -1, 32'h0,      4'b1111, 32'h1111_2222, 32'h0,        1, 5'd5, 16, 18);

      // Reset in the middle of a bus cycle abandons the access.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      ls_op     = 2'b00;
      addr      = 32'h0000_0100;
      repeat (4) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      check("mid_bus_req", bif.bus_req, 1);
      #2 reset_n = 1'b0;
      #1 check("rst_async_bus_req", bif.bus_req, 0);
      check("rst_async_stall", stall, 0);
      @(negedge clk);
      reset_n = 1'b1;
      last_rd = 32'd0;
      begin
         int seen_done;
         seen_done = 0;
         repeat (4) begin
            @(negedge clk);
            if (done) seen_done++;
         end
         check("no_done_after_rst", seen_done, 0);
      end
      check("rdata_after_rst", rdata, 0);

      run_access(0, 2'b01, 0, 32'h0000_0042, 32'h0,        0,  32'h9876_5432, 4'b1100, 32'h0,        32'h0000_9876, 0, 5'd0, 1,  3);

      if (sb.size() != 0) check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Multi-cycle load/store controller between the MEM-stage datapath and the shared data bus (DM plus memory-mapped timers).
- Accepts one access per request.
- Checks alignment and address-range legality.
- Generates byte enables and write-lane data, then runs a req/ack bus handshake with timeout.
- Stalls the pipeline until the access finishes, then returns sign/zero-extended load data or an exception code.

Parameters:
TIMEOUT, 16, bus cycles to wait for bus_ack before flagging a bus error (1..255)
DM_TOP, 32'h0000_2FFF, last legal DM byte address
DEV0_BASE, 32'h0000_7F00, timer0 base; device window is 12 bytes
DEV1_BASE, 32'h0000_7F10, timer1 base; device window is 12 bytes

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM stage presents a load/store this cycle
req_we  in  1  1=store, 0=load
ls_op  in  2  access width: LS_W / LS_H / LS_B
ls_sign  in  1  load sign-extend (1) or zero-extend (0)
addr  in  32  byte address
wdata  in  32  store data (low bits significant)
stall  out  1  hold pipeline; access in flight
done  out  1  one-cycle pulse: access finished
rdata  out  32  extended load data, valid when done && !exc_valid
exc_valid  out  1  pulse with done: access faulted
exc_code  out  5  EXC_ADEL (4) or EXC_ADES (5)
bus_req  out  1  bus request, held until ack
bus_we  out  1  bus write
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  store data placed on its byte lanes
bus_ack  in  1  bus completes transfer (1-cycle pulse)
bus_rdata  in  32  raw read word, valid with bus_ack

Behaviour:
- Reset (async, reset_n=0): state IDLE. stall, done, exc_valid, bus_req and bus_we are 0. exc_code, bus_addr, bus_be, bus_wdata and rdata are 0. The timeout counter is 0.
- Reset mid-access drops bus_req immediately; the access is abandoned and done never pulses.
- States: IDLE -> CHECK -> BUS -> RESP -> IDLE; CHECK -> RESP on a fault.
- IDLE: req_valid=1 latches req_we, ls_op, ls_sign, addr and wdata, then goes to CHECK. stall asserts combinationally in the same cycle and stays high through BUS. It drops in RESP.
- CHECK (1 cycle) faults on any of:
  - misalignment: LS_W with addr[1:0]!=0, or LS_H with addr[0]!=0;
  - addr outside [0, DM_TOP] and outside both device windows;
  - device access with ls_op!=LS_W.
- A fault selects code ADEL for a load and ADES for a store, then goes to RESP with exc_valid. No bus cycle is issued.
- If there is no fault, CHECK registers bus_addr, bus_be and bus_wdata, sets bus_req=1, and goes to BUS.
- bus_be by width:
  - LS_W = 4'b1111;
  - LS_H = 4'b0011 << {addr[1],1'b0};
  - LS_B = 4'b0001 << addr[1:0].
- bus_wdata: word as-is; halfword replicated {wdata[15:0],wdata[15:0]}; byte replicated x4.
- BUS: bus_req, bus_we, bus_addr, bus_be and bus_wdata are stable until bus_ack.
  - On bus_ack: drop bus_req; for a load, capture bus_rdata extended per ls_op/ls_sign/addr[1:0] into rdata; go to RESP.
  - The counter increments every BUS cycle without ack. When it reaches TIMEOUT-1 with no ack: drop bus_req, raise exc ADEL (load) or ADES (store), go to RESP.
  - An ack arriving in that same cycle wins over the timeout.
- RESP (1 cycle): done=1; exc_valid as determined. Returns to IDLE; a new req_valid is not accepted until IDLE.
- For a store, rdata holds its previous value.
- Minimum latency: a request in cycle 0 with ack in cycle 2 gives done in cycle 3. A faulted request gives done in cycle 2.
- req_valid while busy is ignored; the pipeline is stalled by contract.

Decomposition:
- Shared package/header (lsu_defs):
  - LS_W=2'b00, LS_H=2'b01, LS_B=2'b10;
  - EXC_ADEL=5'd4, EXC_ADES=5'd5;
  - state encodings S_IDLE, S_CHECK, S_BUS, S_RESP;
  - device window size (12).
- One natural sub-module, lsu_lane_gen: combinational bus_be, bus_wdata and legality/fault decode from (ls_op, req_we, addr, wdata). The FSM, counter and read extension stay in the top.

Test Plan:
- Word load at 0x0000_0010, ack after 1 BUS cycle with rdata 0xDEADBEEF -> bus_be=1111, done 3 cycles after request, rdata=0xDEADBEEF, no exception.
- Signed byte load at 0x0000_0013, bus_rdata 0x80FF_0102 -> bus_be=1000, rdata=0xFFFF_FF80; same access unsigned -> 0x0000_0080.
- Halfword store 0xABCD1234 at 0x0000_0006 -> bus_be=1100, bus_wdata=0x1234_1234, bus_we=1, done with no exception.
- Word load at 0x0000_0002 -> no bus_req ever, done with exc_valid=1 and exc_code=4 two cycles after request. Byte store to 0x0000_7F04 -> exc_code=5.
- Load at 0x0000_0100 with bus_ack never asserted (TIMEOUT=16) -> bus_req high for exactly 16 cycles, then done with exc_code=4. Stall is held throughout.
- reset_n pulsed low while in BUS -> bus_req and stall drop asynchronously, no done pulse. The next request proceeds normally.
